// File: rtl/peg_move_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : peg_move_arbiter_if
//  Description : Bundles the requester handshakes, the board move/legality
//                signals and the response/status outputs of the peg-solitaire
//                move arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface peg_move_arbiter_if;
    // Requester 0
    logic       req0_valid;
    logic [4:0] req0_from;
    logic [1:0] req0_dir;
    logic       req0_ready;
    // Requester 1
    logic       req1_valid;
    logic [4:0] req1_from;
    logic [1:0] req1_dir;
    logic       req1_ready;
    // Board side
    logic       mv_valid;
    logic [4:0] mv_from;
    logic [1:0] mv_dir;
    logic       brd_legal;
    logic [4:0] brd_cnt;
    // Response and game status
    logic       rsp_valid;
    logic       rsp_id;
    logic       rsp_ok;
    logic [4:0] moves;
    logic       won;
    logic       stuck;

    // Arbiter view
    modport slave (
        input  req0_valid, req0_from, req0_dir,
        input  req1_valid, req1_from, req1_dir,
        input  brd_legal, brd_cnt,
        output req0_ready, req1_ready,
        output mv_valid, mv_from, mv_dir,
        output rsp_valid, rsp_id, rsp_ok,
        output moves, won, stuck
    );

    // Requester / board / environment view
    modport master (
        output req0_valid, req0_from, req0_dir,
        output req1_valid, req1_from, req1_dir,
        output brd_legal, brd_cnt,
        input  req0_ready, req1_ready,
        input  mv_valid, mv_from, mv_dir,
        input  rsp_valid, rsp_id, rsp_ok,
        input  moves, won, stuck
    );
endinterface
`default_nettype wire

// File: rtl/peg_move_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : peg_move_arbiter
//  Description : Round-robin arbiter sharing the 5x5 peg-solitaire board
//                between two move requesters. One move per grant is issued to
//                the board, answered with an accept/reject response, and
//                accepted-move count, win and stuck status are tracked.
//  Revision    : 1.0 - initial release
// ============================================================================
module peg_move_arbiter #(
    parameter int REJ_LIMIT = 15
) (
    input  wire               clk,
    input  wire               rst,
    peg_move_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [4:0] c_max_hole  = 5'd24;
    localparam logic [4:0] c_moves_max = 5'd31;
    localparam logic [3:0] c_rej_max   = 4'd15;
    localparam logic [3:0] c_rej_limit = 4'(REJ_LIMIT);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_last;
    logic [4:0] r_from;
    logic [1:0] r_dir;
    logic       r_id;
    logic       r_ok;
    logic [4:0] r_moves;
    logic [3:0] r_rej;
    logic       r_won;
    logic       r_stuck;

    logic       w_game_over;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_from_ok;
    logic       w_ready0;
    logic       w_ready1;
    logic       w_mv_valid;
    logic       w_rsp_valid;
    logic [3:0] w_rej_inc;
    logic [4:0] w_moves_inc;

    assign w_game_over = r_won | r_stuck;
    assign w_from_ok   = (r_from <= c_max_hole);
    assign w_rej_inc   = (r_rej == c_rej_max) ? r_rej : r_rej + 4'd1;
    assign w_moves_inc = (r_moves == c_moves_max) ? r_moves : r_moves + 5'd1;

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last
    assign w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last);
    assign w_gnt0 = bus.req0_valid & ~w_gnt1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and strobe decode; grants and responses are masked while rst
    // is high because reset discards whatever the cycle would have produced
    always_comb begin
        w_state_next = r_state;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;
        w_mv_valid   = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst && !w_game_over) begin
                    w_ready0 = w_gnt0;
                    w_ready1 = w_gnt1;
                    if (w_gnt0 || w_gnt1) begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Off-board start holes never reach the board
                w_mv_valid   = w_from_ok;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid  = ~rst;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Move capture, legality latch and game bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_from  <= 5'd0;
            r_dir   <= 2'd0;
            r_id    <= 1'b0;
            r_ok    <= 1'b0;
            r_moves <= 5'd0;
            r_rej   <= 4'd0;
            r_won   <= 1'b0;
            r_stuck <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ready0 || w_ready1) begin
                        r_from <= w_ready1 ? bus.req1_from : bus.req0_from;
                        r_dir  <= w_ready1 ? bus.req1_dir  : bus.req0_dir;
                        r_id   <= w_ready1;
                        r_last <= w_ready1;
                    end
                end
                S_ISSUE: begin
                    r_ok <= w_from_ok & bus.brd_legal;
                end
                S_RESP: begin
                    if (r_ok) begin
                        r_moves <= w_moves_inc;
                        r_rej   <= 4'd0;
                        // Board count already reflects the committed move
                        if (bus.brd_cnt == 5'd1) begin
                            r_won <= 1'b1;
                        end
                    end else begin
                        r_rej <= w_rej_inc;
                        if (w_rej_inc == c_rej_limit) begin
                            r_stuck <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.mv_valid   = w_mv_valid;
    assign bus.mv_from    = r_from;
    assign bus.mv_dir     = r_dir;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_ok     = r_ok;
    assign bus.moves      = r_moves;
    assign bus.won        = r_won;
    assign bus.stuck      = r_stuck;

endmodule
`default_nettype wire
